// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtract sequencer: one full_subtractor cell is reused for WIDTH cycles,
// LSB first, with the borrow carried between cycles in a flip-flop.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic Bor_in,
    output logic d,
    output logic Bor_out
);
    assign d       = a ^ b ^ Bor_in;
    assign Bor_out = (~a & b) | (~(a ^ b) & Bor_in);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] d_sr_reg;
    logic             brw_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             zero_reg;
    logic             overflow_reg;

    logic             fs_d;
    logic             fs_bor;
    logic [WIDTH-1:0] d_sr_next;
    logic             last_bit;

    full_subtractor u_fs (
        .a      (a_sr_reg[0]),
        .b      (b_sr_reg[0]),
        .Bor_in (brw_reg),
        .d      (fs_d),
        .Bor_out(fs_bor)
    );

    // The difference fills from the top so that after WIDTH shifts bit 0 lands at index 0.
    assign d_sr_next = {fs_d, d_sr_reg[WIDTH-1:1]};
    assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_sr_reg     <= '0;
            b_sr_reg     <= '0;
            d_sr_reg     <= '0;
            brw_reg      <= 1'b0;
            cnt_reg      <= '0;
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= RUN;
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        d_sr_reg  <= '0;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        brw_reg   <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_reg <= a_sr_reg >> 1;
                    b_sr_reg <= b_sr_reg >> 1;
                    d_sr_reg <= d_sr_next;
                    brw_reg  <= fs_bor;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        state_reg    <= DONE;
                        diff_reg     <= d_sr_next;
                        borrow_reg   <= fs_bor;
                        zero_reg     <= (d_sr_next == '0);
                        overflow_reg <= (a_msb_reg != b_msb_reg) &&
                                        (d_sr_next[WIDTH-1] != a_msb_reg);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = (state_reg == RUN);
    assign done       = (state_reg == DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;
    assign zero       = zero_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of the bit-serial subtractor at WIDTH=8 and WIDTH=32
// against an arithmetic reference model.

module tb_serial_subtractor_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start32;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic        busy8, done8, borrow8, zero8, ovf8;
    logic        busy32, done32, borrow32, zero32, ovf32;
    logic [7:0]  diff8;
    logic [31:0] diff32;

    int n_vec = 0;
    int n_err = 0;
    bit sel32 = 1'b0;

    logic        busy_m, done_m, borrow_m, zero_m, ovf_m;
    logic [63:0] diff_m;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8),
        .zero(zero8), .overflow(ovf8)
    );

    serial_subtractor_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32), .borrow_out(borrow32),
        .zero(zero32), .overflow(ovf32)
    );

    assign busy_m   = sel32 ? busy32   : busy8;
    assign done_m   = sel32 ? done32   : done8;
    assign borrow_m = sel32 ? borrow32 : borrow8;
    assign zero_m   = sel32 ? zero32   : zero8;
    assign ovf_m    = sel32 ? ovf32    : ovf8;
    assign diff_m   = sel32 ? {32'b0, diff32} : {56'b0, diff8};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on the operand values.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] ed, output logic eb, output logic ez,
                         output logic eo);
        longint mask, sa, sb, sd, smax, smin;
        mask = (longint'(1) << w) - 1;
        ed   = (av - bv) & mask;
        eb   = (av < bv);
        ez   = (ed == 0);
        sa   = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
        sb   = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
        sd   = sa - sb;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        eo   = (sd > smax) || (sd < smin);
    endtask

    task automatic drive(input int w, input logic s, input logic [63:0] av, input logic [63:0] bv);
        sel32 = (w == 32);
        if (w == 32) begin
            start32 = s; a32 = av[31:0]; b32 = bv[31:0];
        end else begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    task automatic op(input int w, input logic [63:0] av, input logic [63:0] bv, input string tag);
        logic [63:0] ed;
        logic        eb, ez, eo;
        int          bc, both;
        bit          got;
        model(w, av, bv, ed, eb, ez, eo);
        @(negedge clk);
        drive(w, 1'b1, av, bv);
        @(negedge clk);
        drive(w, 1'b0, '0, '0);
        bc = 0; both = 0; got = 0;
        for (int i = 0; i < w + 5; i++) begin
            if (busy_m && done_m) both++;
            if (done_m) begin
                got = 1;
                break;
            end
            if (busy_m) bc++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(w));
        chk({tag, "_busy_done_overlap"}, 64'(both), 64'd0);
        chk({tag, "_diff"}, diff_m, ed);
        chk({tag, "_borrow"}, 64'(borrow_m), 64'(eb));
        chk({tag, "_zero"}, 64'(zero_m), 64'(ez));
        chk({tag, "_ovf"}, 64'(ovf_m), 64'(eo));
        $display("op %s w=%0d a=%0h b=%0h diff=%0h borrow=%0b zero=%0b ovf=%0b",
                 tag, w, av, bv, diff_m, borrow_m, zero_m, ovf_m);
        @(negedge clk);
        chk({tag, "_done_fall"}, 64'(done_m), 64'd0);
    endtask

    initial begin
        int t1, t2, bc, dn;
        rst_n = 1'b0;
        drive(32, 1'b0, '0, '0);
        drive(8, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst8_outs", {busy8, done8, borrow8, zero8, ovf8, 8'(diff8)}, 64'd0);
        chk("rst32_outs", {busy32, done32, borrow32, zero32, ovf32, diff32}, 64'd0);

        op(8, 64'h05, 64'h03, "d8_05_03");
        op(8, 64'h03, 64'h05, "d8_03_05");
        op(8, 64'h80, 64'h01, "d8_80_01");
        op(8, 64'h3C, 64'h3C, "d8_3c_3c");

        // Second request during RUN must be ignored.
        @(negedge clk);
        drive(8, 1'b1, 64'h10, 64'h20);
        @(negedge clk);
        drive(8, 1'b0, '0, '0);
        bc = 0; dn = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) drive(8, 1'b1, 64'hFF, 64'h00);
            if (i == 4) drive(8, 1'b0, '0, '0);
            if (busy8) bc++;
            if (done8) begin
                dn++;
                chk("ign_diff", 64'(diff8), 64'hF0);
                chk("ign_borrow", 64'(borrow8), 64'd1);
            end
            @(negedge clk);
        end
        chk("ign_busy_cycles", 64'(bc), 64'd8);
        chk("ign_done_count", 64'(dn), 64'd1);
        $display("op ignored-start diff=%0h borrow=%0b dones=%0d", diff8, borrow8, dn);

        // Reset in the middle of RUN aborts without a done.
        @(negedge clk);
        drive(8, 1'b1, 64'h55, 64'h22);
        @(negedge clk);
        drive(8, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_outs", {busy8, done8, borrow8, zero8, ovf8, 8'(diff8)}, 64'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) dn++;
            @(negedge clk);
        end
        chk("abort_no_activity", 64'(dn), 64'd0);
        $display("op abort diff=%0h busy=%0b done=%0b", diff8, busy8, done8);

        // Back-to-back with start held high.
        drive(8, 1'b1, 64'h09, 64'h04);
        @(negedge clk);
        drive(8, 1'b1, 64'h00, 64'h01);
        t1 = -1; t2 = -1;
        for (int t = 1; t <= 40; t++) begin
            if (done8) begin
                chk("b2b_busy_in_done", 64'(busy8), 64'd0);
                if (t1 < 0) begin
                    t1 = t;
                    chk("b2b_diff1", 64'(diff8), 64'h05);
                    chk("b2b_borrow1", 64'(borrow8), 64'd0);
                end else begin
                    t2 = t;
                    chk("b2b_diff2", 64'(diff8), 64'hFF);
                    chk("b2b_borrow2", 64'(borrow8), 64'd1);
                    drive(8, 1'b0, '0, '0);
                    break;
                end
            end
            if (t1 > 0 && t == t1 + 3) begin
                chk("b2b_hold_diff", 64'(diff8), 64'h05);
                chk("b2b_second_busy", 64'(busy8), 64'd1);
            end
            @(negedge clk);
        end
        drive(8, 1'b0, '0, '0);
        chk("b2b_spacing", 64'(t2 - t1), 64'd9);
        $display("op back-to-back t1=%0d t2=%0d diff=%0h borrow=%0b", t1, t2, diff8, borrow8);

        for (int k = 0; k < 500; k++) begin
            op(32, 64'($urandom), 64'($urandom), "rnd32");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
